// File: rtl/teachee_defs.sv
// Shared XADC DRP definitions: address type, channel map, widths and the
// responder FSM state type.
package teachee_defs;

   typedef logic [6:0] xadc_drp_addr_t;

   localparam xadc_drp_addr_t XADC_DRP_ADDR_VOLTAGE_CHANNEL = 7'h03;
   localparam xadc_drp_addr_t XADC_DRP_ADDR_CURRENT_CHANNEL = 7'h10;

   localparam int XADC_DRP_DATA_WIDTH = 16;
   localparam int XADC_SAMPLE_WIDTH   = 12;

   typedef enum logic [1:0] {
      XADC_DRP_IDLE    = 2'd0,
      XADC_DRP_WAIT    = 2'd1,
      XADC_DRP_RESPOND = 2'd2
   } xadc_drp_responder_state_t;

   // The XADC reports 12-bit conversions left-justified in the 16-bit DRP word.
   function automatic logic [XADC_DRP_DATA_WIDTH-1:0] xadc_sample_to_drp(
      input logic [XADC_SAMPLE_WIDTH-1:0] sample
   );
      return {sample, 4'b0000};
   endfunction

endpackage

// File: rtl/xadc_sample_ramp.sv
// Deterministic 12-bit sample source: adds STEP on every advance pulse,
// wrapping modulo 4096.
module xadc_sample_ramp
   import teachee_defs::*;
#(
   parameter logic [XADC_SAMPLE_WIDTH-1:0] STEP = 12'h001
) (
   input  logic                         xadc_dclk,
   input  logic                         xadc_reset,
   input  logic                         advance,
   output logic [XADC_SAMPLE_WIDTH-1:0] value
);

   logic [XADC_SAMPLE_WIDTH-1:0] value_reg;

   always_ff @(posedge xadc_dclk) begin
      if (xadc_reset) begin
         value_reg <= '0;
      end else if (advance) begin
         value_reg <= value_reg + STEP;
      end
   end

   assign value = value_reg;

endmodule

// File: rtl/xadc_drp_responder_model.sv
// Simulation/bring-up stand-in for the XADC DRP responder: ramp samples on two
// channel addresses, periodic eos, fixed-latency drdy and protocol checking.
module xadc_drp_responder_model
   import teachee_defs::*;
#(
   parameter int                           DRP_LATENCY  = 4,
   parameter int                           EOS_PERIOD   = 32,
   parameter logic [XADC_SAMPLE_WIDTH-1:0] VOLTAGE_STEP = 12'h010,
   parameter logic [XADC_SAMPLE_WIDTH-1:0] CURRENT_STEP = 12'h001
) (
   input  logic                           xadc_dclk,
   input  logic                           xadc_reset,
   input  xadc_drp_addr_t                 xadc_daddr,
   input  logic                           xadc_den,
   output logic                           xadc_drdy,
   output logic [XADC_DRP_DATA_WIDTH-1:0] xadc_do,
   output logic                           xadc_eos,
   output logic                           protocol_error
);

   localparam int EOS_CNT_W = (EOS_PERIOD > 2) ? $clog2(EOS_PERIOD) : 1;
   localparam logic [EOS_CNT_W-1:0] EOS_LAST = EOS_CNT_W'(EOS_PERIOD - 1);
   localparam logic [EOS_CNT_W-1:0] EOS_PRE  = EOS_CNT_W'(EOS_PERIOD - 2);
   localparam logic [3:0]           LAT_LOAD = 4'(DRP_LATENCY - 1);
   localparam logic [XADC_SAMPLE_WIDTH-1:0] RAMP_STEP [2] = '{VOLTAGE_STEP, CURRENT_STEP};

   logic [EOS_CNT_W-1:0]           eos_cnt_reg, eos_cnt_next;
   logic                           eos_reg;
   logic                           ramp_advance;
   logic [XADC_SAMPLE_WIDTH-1:0]   ramp_value [2];

   xadc_drp_responder_state_t      state_reg, state_next;
   logic [3:0]                     lat_cnt_reg, lat_cnt_next;
   logic [XADC_DRP_DATA_WIDTH-1:0] data_reg, data_next;
   logic                           perr_reg, perr_next;

   // Ramps step on the edge that raises eos, so the eos cycle already
   // exposes the new sample values.
   assign ramp_advance = (eos_cnt_reg == EOS_PRE);
   assign eos_cnt_next = (eos_cnt_reg == EOS_LAST) ? '0 : eos_cnt_reg + EOS_CNT_W'(1);

   always_ff @(posedge xadc_dclk) begin
      if (xadc_reset) begin
         eos_cnt_reg <= '0;
         eos_reg     <= 1'b0;
      end else begin
         eos_cnt_reg <= eos_cnt_next;
         eos_reg     <= ramp_advance;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ramp
         xadc_sample_ramp #(
            .STEP (RAMP_STEP[gi])
         ) u_ramp (
            .xadc_dclk  (xadc_dclk),
            .xadc_reset (xadc_reset),
            .advance    (ramp_advance),
            .value      (ramp_value[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next   = state_reg;
      lat_cnt_next = lat_cnt_reg;
      data_next    = data_reg;
      perr_next    = perr_reg;
      case (state_reg)
         XADC_DRP_IDLE: begin
            if (xadc_den) begin
               lat_cnt_next = LAT_LOAD;
               state_next   = (DRP_LATENCY == 1) ? XADC_DRP_RESPOND : XADC_DRP_WAIT;
               case (xadc_daddr)
                  XADC_DRP_ADDR_VOLTAGE_CHANNEL: data_next = xadc_sample_to_drp(ramp_value[0]);
                  XADC_DRP_ADDR_CURRENT_CHANNEL: data_next = xadc_sample_to_drp(ramp_value[1]);
                  default: begin
                     data_next = '0;
                     perr_next = 1'b1;
                  end
               endcase
            end
         end
         XADC_DRP_WAIT: begin
            lat_cnt_next = lat_cnt_reg - 4'd1;
            if (lat_cnt_reg <= 4'd1) begin
               state_next = XADC_DRP_RESPOND;
            end
            if (xadc_den) begin
               perr_next = 1'b1;
            end
         end
         XADC_DRP_RESPOND: begin
            // The return-to-idle cycle is still busy; a den here is dropped.
            state_next = XADC_DRP_IDLE;
            if (xadc_den) begin
               perr_next = 1'b1;
            end
         end
         default: state_next = XADC_DRP_IDLE;
      endcase
   end

   always_ff @(posedge xadc_dclk) begin
      if (xadc_reset) begin
         state_reg   <= XADC_DRP_IDLE;
         lat_cnt_reg <= '0;
         data_reg    <= '0;
         perr_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         lat_cnt_reg <= lat_cnt_next;
         data_reg    <= data_next;
         perr_reg    <= perr_next;
      end
   end

   assign xadc_drdy      = (state_reg == XADC_DRP_RESPOND);
   assign xadc_do        = xadc_drdy ? data_reg : '0;
   assign xadc_eos       = eos_reg;
   assign protocol_error = perr_reg;

endmodule

// File: tb/tb_xadc_drp_responder_model.sv
// Scoreboard bench: two responders (latency 4 and latency 1) share clock and
// reset; expected reads are queued at issue time and checked by monitors.
module tb_xadc_drp_responder_model;
   import teachee_defs::*;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   xadc_drp_addr_t addr0 = '0, addr1 = '0;
   logic           den0 = 1'b0, den1 = 1'b0;
   logic           drdy0, drdy1, eos0, eos1, perr0, perr1;
   logic [15:0]    do0, do1;

   int   cyc = 0;
   int   tests = 0;
   int   failed = 0;
   bit   mon_en = 1'b0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   // cyc = 1 in the first cycle after reset is released; eos due when cyc%32==0
   always @(posedge clk) cyc <= rst ? 1 : cyc + 1;

   xadc_drp_responder_model dut0 (
      .xadc_dclk      (clk),
      .xadc_reset     (rst),
      .xadc_daddr     (addr0),
      .xadc_den       (den0),
      .xadc_drdy      (drdy0),
      .xadc_do        (do0),
      .xadc_eos       (eos0),
      .protocol_error (perr0)
   );

   xadc_drp_responder_model #(.DRP_LATENCY(1)) dut1 (
      .xadc_dclk      (clk),
      .xadc_reset     (rst),
      .xadc_daddr     (addr1),
      .xadc_den       (den1),
      .xadc_drdy      (drdy1),
      .xadc_do        (do1),
      .xadc_eos       (eos1),
      .protocol_error (perr1)
   );

   function automatic logic [15:0] exp_data(input logic [6:0] a, input int k);
      int          n;
      logic [11:0] v;
      n = k / 32;
      if (a == XADC_DRP_ADDR_VOLTAGE_CHANNEL)      v = 12'((n * 16) % 4096);
      else if (a == XADC_DRP_ADDR_CURRENT_CHANNEL) v = 12'(n % 4096);
      else                                         v = 12'h000;
      return {v, 4'h0};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, act, req);
      end
   endtask

   task automatic issue(input int which, input logic [6:0] a, input bit accept);
      exp_t e;
      e.data = exp_data(a, cyc);
      if (which == 0) begin
         addr0 = a; den0 = 1'b1; e.due = cyc + 4;
         if (accept) q0.push_back(e);
      end else begin
         addr1 = a; den1 = 1'b1; e.due = cyc + 1;
         if (accept) q1.push_back(e);
      end
      $display("[TB] dut%0d den addr=%h cycle %0d", which, a, cyc);
      @(negedge clk);
      den0 = 1'b0;
      den1 = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      for (int i = 0; i < 20000 && cyc < target; i++) @(negedge clk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      chk("drain_pending", 16'(q0.size() + q1.size()), 16'h0000);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         chk("dut0_eos", {15'b0, eos0}, {15'b0, (cyc % 32) == 0});
         if (drdy0 === 1'b1) begin
            if (q0.size() == 0) begin
               chk("dut0_spurious_drdy", {15'b0, drdy0}, 16'h0000);
            end else begin
               e = q0.pop_front();
               $display("[TB] dut0 drdy cycle %0d do=%h", cyc, do0);
               chk("dut0_do", do0, e.data);
               chk("dut0_latency", 16'(cyc), 16'(e.due));
            end
         end else begin
            chk("dut0_idle_do", do0, 16'h0000);
            if (q0.size() != 0 && q0[0].due <= cyc) begin
               chk("dut0_missed_drdy", {15'b0, drdy0}, 16'h0001);
               q0.delete(0);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         chk("dut1_eos", {15'b0, eos1}, {15'b0, (cyc % 32) == 0});
         if (drdy1 === 1'b1) begin
            if (q1.size() == 0) begin
               chk("dut1_spurious_drdy", {15'b0, drdy1}, 16'h0000);
            end else begin
               e = q1.pop_front();
               $display("[TB] dut1 drdy cycle %0d do=%h", cyc, do1);
               chk("dut1_do", do1, e.data);
               chk("dut1_latency", 16'(cyc), 16'(e.due));
            end
         end else begin
            chk("dut1_idle_do", do1, 16'h0000);
            if (q1.size() != 0 && q1[0].due <= cyc) begin
               chk("dut1_missed_drdy", {15'b0, drdy1}, 16'h0001);
               q1.delete(0);
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      chk("reset_perr0", {15'b0, perr0}, 16'h0000);
      chk("reset_perr1", {15'b0, perr1}, 16'h0000);
      rst = 1'b0;

      // first reads after the first eos
      wait_cyc(37);
      issue(0, XADC_DRP_ADDR_VOLTAGE_CHANNEL, 1'b1);
      wait_drain();
      chk("perr0_after_good_read", {15'b0, perr0}, 16'h0000);
      issue(0, XADC_DRP_ADDR_CURRENT_CHANNEL, 1'b1);
      wait_drain();

      // eos coincidence: den at 63 on dut0, den at 64 (eos cycle) on dut1
      wait_cyc(63);
      issue(0, XADC_DRP_ADDR_VOLTAGE_CHANNEL, 1'b1);
      issue(1, XADC_DRP_ADDR_VOLTAGE_CHANNEL, 1'b1);
      wait_drain();
      wait_cyc(96);
      issue(0, XADC_DRP_ADDR_VOLTAGE_CHANNEL, 1'b1);
      wait_drain();

      // wrap after 256 eos pulses, then dens in WAIT and RESPOND are dropped
      wait_cyc(256 * 32 + 3);
      issue(0, XADC_DRP_ADDR_VOLTAGE_CHANNEL, 1'b1);
      @(negedge clk);
      issue(0, XADC_DRP_ADDR_VOLTAGE_CHANNEL, 1'b0);
      @(negedge clk);
      issue(0, XADC_DRP_ADDR_CURRENT_CHANNEL, 1'b0);
      wait_drain();
      chk("perr0_busy_den", {15'b0, perr0}, 16'h0001);
      issue(0, XADC_DRP_ADDR_CURRENT_CHANNEL, 1'b1);
      wait_drain();
      chk("perr0_sticky", {15'b0, perr0}, 16'h0001);
      chk("perr1_untouched", {15'b0, perr1}, 16'h0000);

      // bad address, then reset during a pending read
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("perr0_cleared_by_reset", {15'b0, perr0}, 16'h0000);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      issue(0, 7'h7F, 1'b1);
      wait_drain();
      chk("perr0_bad_addr", {15'b0, perr0}, 16'h0001);
      issue(0, XADC_DRP_ADDR_VOLTAGE_CHANNEL, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      q0.delete();
      repeat (3) @(negedge clk);
      chk("reset_mid_read_perr0", {15'b0, perr0}, 16'h0000);
      chk("reset_mid_read_drdy0", {15'b0, drdy0}, 16'h0000);
      chk("reset_mid_read_do0", do0, 16'h0000);
      chk("reset_mid_read_eos0", {15'b0, eos0}, 16'h0000);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // latency-1 responder: back-to-back dens every 2 cycles across an eos
      wait_cyc(28);
      for (int i = 0; i < 6; i++) begin
         issue(1, (i % 2 == 0) ? XADC_DRP_ADDR_VOLTAGE_CHANNEL : XADC_DRP_ADDR_CURRENT_CHANNEL, 1'b1);
         @(negedge clk);
      end
      wait_drain();
      chk("perr1_back_to_back", {15'b0, perr1}, 16'h0000);

      repeat (4) @(negedge clk);
      chk("final_queues_empty", 16'(q0.size() + q1.size()), 16'h0000);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
